// File: rtl/ir_disp_arb_pkg.sv
// Shared types and defaults for the IR / background display arbiter.
// Imported by the arbiter top and its millisecond timer.
package ir_disp_arb_pkg;

  typedef enum logic [1:0] {
    ST_BG   = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int CNT_1MS_DEF = 50_000;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ir_disp_arb_ms_timer.sv
// Millisecond timebase with a selectable last-ms index.
// done_o pulses on the final cycle of the selected interval.
module ir_disp_arb_ms_timer
  import ir_disp_arb_pkg::*;
#(
  parameter  int CNT_1MS = CNT_1MS_DEF,
  parameter  int MAX_MS  = 3000,
  localparam int UW      = cw(CNT_1MS),
  localparam int MW      = cw(MAX_MS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [MW-1:0] last_ms_i,
  output logic          done_o
);

  logic [UW-1:0] us_q, us_d;
  logic [MW-1:0] ms_q, ms_d;
  logic          us_wrap;

  assign us_wrap = (us_q == UW'(CNT_1MS - 1));
  assign done_o  = us_wrap & (ms_q == last_ms_i);

  always_comb begin
    us_d = us_wrap ? '0 : us_q + 1'b1;
    ms_d = ms_q;
    if (us_wrap) begin
      ms_d = (ms_q == MW'(MAX_MS - 1)) ? '0 : ms_q + 1'b1;
    end
    if (clr_i) begin
      us_d = '0;
      ms_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      us_q <= '0;
      ms_q <= '0;
    end else begin
      us_q <= us_d;
      ms_q <= ms_d;
    end
  end

endmodule

// File: rtl/ir_disp_arb.sv
// Shares the 6-digit display between the IR receiver and a background source.
// IR frames/repeats pre-empt the background, hold, blank, then hand back.
module ir_disp_arb
  import ir_disp_arb_pkg::*;
#(
  parameter int CNT_1MS = CNT_1MS_DEF,
  parameter int HOLD_MS = 3000,
  parameter int GAP_MS  = 200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] ir_data,
  input  logic        repeat_en,
  input  logic [19:0] bg_data,
  input  logic [5:0]  bg_point,
  input  logic        bg_sign,
  input  logic        bg_en,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic        ir_active
);

  localparam int MAX_MS = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
  localparam int MW     = cw(MAX_MS);

  state_e      st_q, st_d;
  logic        armed_q;
  logic [19:0] ir_prev_q;
  logic        rep_d_q;
  logic        nf_q, re_q;
  logic [19:0] lat_q, lat_d;
  logic [19:0] data_q, data_d;
  logic [5:0]  point_q, point_d;
  logic        sign_q, sign_d;
  logic        seg_en_q, seg_en_d;
  logic        act_q, act_d;
  logic        trig, clr, done;
  logic [MW-1:0] last_ms;

  // armed_q masks the first cycle after reset so a value that was
  // already present on ir_data is taken as the baseline, not a frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed_q   <= 1'b0;
      ir_prev_q <= '0;
      rep_d_q   <= 1'b0;
      nf_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      armed_q   <= 1'b1;
      ir_prev_q <= ir_data;
      rep_d_q   <= repeat_en;
      nf_q      <= armed_q & (ir_data != ir_prev_q);
      re_q      <= armed_q & repeat_en & ~rep_d_q;
    end
  end

  assign trig    = nf_q | re_q;
  assign clr     = trig | (st_d != st_q);
  assign last_ms = (st_q == ST_GAP) ? MW'(GAP_MS - 1) : MW'(HOLD_MS - 1);

  ir_disp_arb_ms_timer #(
    .CNT_1MS (CNT_1MS),
    .MAX_MS  (MAX_MS)
  ) u_tmr (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .clr_i     (clr),
    .last_ms_i (last_ms),
    .done_o    (done)
  );

  always_comb begin
    st_d  = st_q;
    lat_d = lat_q;
    unique case (st_q)
      ST_BG: begin
        if (trig) begin
          st_d  = ST_SHOW;
          lat_d = ir_prev_q;
        end
      end
      ST_SHOW: begin
        if (nf_q) lat_d = ir_prev_q;
        if (!trig && done) st_d = ST_GAP;
      end
      ST_GAP: begin
        if (nf_q) lat_d = ir_prev_q;
        if (trig) st_d = ST_SHOW;
        else if (done) st_d = ST_BG;
      end
      default: st_d = ST_BG;
    endcase
  end

  always_comb begin
    data_d   = lat_d;
    point_d  = '0;
    sign_d   = 1'b0;
    seg_en_d = 1'b0;
    act_d    = 1'b0;
    if (st_d == ST_BG) begin
      data_d   = bg_data;
      point_d  = bg_point;
      sign_d   = bg_sign;
      seg_en_d = bg_en;
    end else if (st_d == ST_SHOW) begin
      seg_en_d = 1'b1;
      act_d    = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q     <= ST_BG;
      lat_q    <= '0;
      data_q   <= '0;
      point_q  <= '0;
      sign_q   <= 1'b0;
      seg_en_q <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      lat_q    <= lat_d;
      data_q   <= data_d;
      point_q  <= point_d;
      sign_q   <= sign_d;
      seg_en_q <= seg_en_d;
      act_q    <= act_d;
    end
  end

  assign data      = data_q;
  assign point     = point_q;
  assign sign      = sign_q;
  assign seg_en    = seg_en_q;
  assign ir_active = act_q;

endmodule

// File: tb/tb_ir_disp_arb.sv
// Randomised bench for ir_disp_arb against a timeline reference model.
// Each trigger opens a 50-cycle IR window, then a 20-cycle blank.
module tb_ir_disp_arb;

  localparam int HOLD = 50;
  localparam int GAP  = 20;
  localparam int N    = 8192;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [19:0] ir_data;
  logic        repeat_en;
  logic [19:0] bg_data;
  logic [5:0]  bg_point;
  logic        bg_sign;
  logic        bg_en;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic        ir_active;

  ir_disp_arb #(
    .CNT_1MS (10),
    .HOLD_MS (5),
    .GAP_MS  (2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ir_data   (ir_data),
    .repeat_en (repeat_en),
    .bg_data   (bg_data),
    .bg_point  (bg_point),
    .bg_sign   (bg_sign),
    .bg_en     (bg_en),
    .data      (data),
    .point     (point),
    .sign      (sign),
    .seg_en    (seg_en),
    .ir_active (ir_active)
  );

  always #5 sys_clk = ~sys_clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int rel    = N;
  int lastk  = -1;

  logic [19:0] h_ir  [N];
  logic        h_rep [N];
  logic        h_rst [N];
  logic [19:0] h_bgd [N];
  logic [5:0]  h_bgp [N];
  logic        h_bgs [N];
  logic        h_bge [N];
  logic        trg   [N];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_all(input logic [19:0] d, input logic [5:0] p,
                         input logic s, input logic e, input logic a);
    chk("data", 32'(data), 32'(d));
    chk("point", 32'(point), 32'(p));
    chk("sign", 32'(sign), 32'(s));
    chk("seg_en", 32'(seg_en), 32'(e));
    chk("ir_active", 32'(ir_active), 32'(a));
  endtask

  task automatic expect_now();
    int d;
    if (!h_rst[cyc-1]) begin
      chk_all('0, '0, 1'b0, 1'b0, 1'b0);
    end else if (lastk < 0 || (cyc - lastk - 2) >= HOLD + GAP) begin
      chk_all(h_bgd[cyc-1], h_bgp[cyc-1], h_bgs[cyc-1], h_bge[cyc-1], 1'b0);
    end else begin
      d = cyc - lastk - 2;
      if (d < HOLD) chk_all(h_ir[lastk], '0, 1'b0, 1'b1, 1'b1);
      else chk_all(h_ir[lastk], '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Record this cycle's inputs, advance one clock, then compare.
  task automatic tick();
    h_ir[cyc]  = ir_data;
    h_rep[cyc] = repeat_en;
    h_rst[cyc] = sys_rst_n;
    h_bgd[cyc] = bg_data;
    h_bgp[cyc] = bg_point;
    h_bgs[cyc] = bg_sign;
    h_bge[cyc] = bg_en;
    if (cyc > 0 && sys_rst_n && !h_rst[cyc-1]) rel = cyc;
    trg[cyc] = 1'b0;
    if (cyc > 0 && sys_rst_n && cyc >= rel + 1)
      trg[cyc] = (h_ir[cyc] != h_ir[cyc-1]) ||
                 (h_rep[cyc] && !h_rep[cyc-1]);
    @(posedge sys_clk);
    #1;
    cyc++;
    if (cyc >= 2 && trg[cyc-2]) lastk = cyc - 2;
    if (!h_rst[cyc-1]) lastk = -1;
    expect_now();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    chk_all('0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ir_data   = '0;
    repeat_en = 1'b0;
    bg_data   = 20'd123456;
    bg_point  = '0;
    bg_sign   = 1'b0;
    bg_en     = 1'b1;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (5) tick();

    ir_data = 20'h00045;
    repeat (80) tick();

    ir_data = 20'h00077;
    repeat (40) tick();
    repeat_en = 1'b1;
    repeat (30) tick();
    repeat_en = 1'b0;
    repeat (80) tick();

    ir_data = 20'h00021;
    repeat (55) tick();
    ir_data = 20'h00016;
    repeat (80) tick();

    ir_data = 20'h00033;
    repeat (50) tick();
    ir_data   = 20'h00034;
    repeat_en = 1'b1;
    repeat (80) tick();
    repeat_en = 1'b0;
    repeat (5) tick();

    ir_data = 20'h0005a;
    repeat (20) tick();
    do_reset();
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (30) tick();

    for (int i = 0; i < 2500; i++) begin
      bg_data  = 20'($urandom);
      bg_point = 6'($urandom);
      bg_sign  = 1'($urandom);
      bg_en    = 1'($urandom);
      if ($urandom_range(0, 89) == 0) ir_data = 20'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        tick();
        tick();
        sys_rst_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
